// File: rtl/mul16_pp_sched.sv
// rtl/mul16_pp_sched.sv - two-requester scheduler/sequencer for the dual-lane 16x16 partial-product multiplier
// Optional signed correction is built when MUL_SCHED_SIGNED_EN is defined.
module mul16_pp_sched #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req0_signed,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic        req1_signed,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_id,
  output logic [31:0] resp_p0,
  output logic [31:0] resp_p1,
  output logic        resp_err,
  output logic        acc_start,
  input  logic        acc_done,
  input  logic [31:0] acc_p0,
  input  logic [31:0] acc_p1,
  output logic [7:0]  ma0,
  output logic [7:0]  mb0,
  output logic [7:0]  ma1,
  output logic [7:0]  mb1
);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_PP1, S_PP2, S_PP3, S_PP4, S_WAIT, S_RESP, S_DRAIN
  } state_t;

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t        state_q, state_d;
  logic          last_q, last_d;
  logic [31:0]   a_q, a_d, b_q, b_d;
  logic          id_q, id_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   p0_q, p0_d, p1_q, p1_d;
  logic          err_q, err_d;
  logic          pick;
  logic [15:0]   oa0, ob0, oa1, ob1;
  logic [31:0]   cap0, cap1;

`ifdef MUL_SCHED_SIGNED_EN
  logic sgn_q, sgn_d;
  logic neg0, neg1;

  // Operand magnitudes to the multipliers and sign fix-up of the accumulated product
  always_comb begin
    oa0  = (sgn_q && a_q[15]) ? (16'd0 - a_q[15:0])  : a_q[15:0];
    ob0  = (sgn_q && b_q[15]) ? (16'd0 - b_q[15:0])  : b_q[15:0];
    oa1  = (sgn_q && a_q[31]) ? (16'd0 - a_q[31:16]) : a_q[31:16];
    ob1  = (sgn_q && b_q[31]) ? (16'd0 - b_q[31:16]) : b_q[31:16];
    neg0 = sgn_q & (a_q[15] ^ b_q[15]);
    neg1 = sgn_q & (a_q[31] ^ b_q[31]);
    cap0 = neg0 ? (32'd0 - acc_p0) : acc_p0;
    cap1 = neg1 ? (32'd0 - acc_p1) : acc_p1;
  end
`else
  logic unused_signed;
  assign unused_signed = req0_signed ^ req1_signed;

  // Unsigned build: operands and products pass straight through
  always_comb begin
    oa0  = a_q[15:0];
    ob0  = b_q[15:0];
    oa1  = a_q[31:16];
    ob1  = b_q[31:16];
    cap0 = acc_p0;
    cap1 = acc_p1;
  end
`endif

  // Round-robin: the requester not granted last wins a tie
  assign pick       = (req0_valid & req1_valid) ? ~last_q : req1_valid;
  assign req0_ready = (state_q == S_IDLE) & req0_valid & ~pick;
  assign req1_ready = (state_q == S_IDLE) & req1_valid & pick;

  assign acc_start  = state_q inside {S_START, S_PP1, S_PP2, S_PP3, S_PP4, S_WAIT};
  assign resp_valid = (state_q == S_RESP);
  assign resp_id    = id_q;
  assign resp_p0    = p0_q;
  assign resp_p1    = p1_q;
  assign resp_err   = err_q;

  // Byte operand selection per partial-product phase; zero outside PP1..PP4
  always_comb begin
    ma0 = 8'd0;
    mb0 = 8'd0;
    ma1 = 8'd0;
    mb1 = 8'd0;
    case (state_q)
      S_PP1: begin ma0 = oa0[7:0];  mb0 = ob0[7:0];  ma1 = oa1[7:0];  mb1 = ob1[7:0];  end
      S_PP2: begin ma0 = oa0[7:0];  mb0 = ob0[15:8]; ma1 = oa1[7:0];  mb1 = ob1[15:8]; end
      S_PP3: begin ma0 = oa0[15:8]; mb0 = ob0[7:0];  ma1 = oa1[15:8]; mb1 = ob1[7:0];  end
      S_PP4: begin ma0 = oa0[15:8]; mb0 = ob0[15:8]; ma1 = oa1[15:8]; mb1 = ob1[15:8]; end
      default: ;
    endcase
  end

  // Sequencer next-state: accept, walk the PP phases, wait for done/timeout, respond, drain
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    a_d     = a_q;
    b_d     = b_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    p0_d    = p0_q;
    p1_d    = p1_q;
    err_d   = err_q;
`ifdef MUL_SCHED_SIGNED_EN
    sgn_d   = sgn_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req0_valid | req1_valid) begin
          last_d  = pick;
          id_d    = pick;
          a_d     = pick ? req1_a : req0_a;
          b_d     = pick ? req1_b : req0_b;
`ifdef MUL_SCHED_SIGNED_EN
          sgn_d   = pick ? req1_signed : req0_signed;
`endif
          state_d = S_START;
        end
      end
      S_START: state_d = S_PP1;
      S_PP1:   state_d = S_PP2;
      S_PP2:   state_d = S_PP3;
      S_PP3:   state_d = S_PP4;
      S_PP4: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q + CW'(1);
        if (acc_done) begin
          p0_d    = cap0;
          p1_d    = cap1;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          p0_d    = 32'd0;
          p1_d    = 32'd0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP:  if (resp_ready) state_d = S_DRAIN;
      S_DRAIN: if (!acc_done)  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and captured-operation registers; async reset clears everything
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      last_q  <= 1'b1;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      id_q    <= 1'b0;
      cnt_q   <= '0;
      p0_q    <= 32'd0;
      p1_q    <= 32'd0;
      err_q   <= 1'b0;
`ifdef MUL_SCHED_SIGNED_EN
      sgn_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      a_q     <= a_d;
      b_q     <= b_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      p0_q    <= p0_d;
      p1_q    <= p1_d;
      err_q   <= err_d;
`ifdef MUL_SCHED_SIGNED_EN
      sgn_q   <= sgn_d;
`endif
    end
  end

endmodule

// File: tb/tb_mul16_pp_sched.sv
// tb/tb_mul16_pp_sched.sv - directed self-checking bench for mul16_pp_sched with a 4-phase accumulator model
module tb_mul16_pp_sched;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        req0_signed, req1_signed;
  logic        resp_valid, resp_ready, resp_id, resp_err;
  logic [31:0] resp_p0, resp_p1;
  logic        acc_start, acc_done;
  logic [31:0] acc_p0, acc_p1;
  logic [7:0]  ma0, mb0, ma1, mb1;
  logic        acc_hang;

  int cyc = 0;
  int t_acc = 0;
  int n_tests = 0;
  int n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mul16_pp_sched #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_signed(req0_signed),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_signed(req1_signed),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_p0(resp_p0), .resp_p1(resp_p1), .resp_err(resp_err),
    .acc_start(acc_start), .acc_done(acc_done), .acc_p0(acc_p0), .acc_p1(acc_p1),
    .ma0(ma0), .mb0(mb0), .ma1(ma1), .mb1(mb1)
  );

  // Accumulator model: sums the byte partial products while acc_start is held, done after phase 6
  int acc_cnt;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_cnt <= 0; acc_done <= 1'b0; acc_p0 <= 32'd0; acc_p1 <= 32'd0;
    end else if (!acc_start) begin
      acc_cnt <= 0; acc_done <= 1'b0; acc_p0 <= 32'd0; acc_p1 <= 32'd0;
    end else begin
      acc_cnt <= acc_cnt + 1;
      case (acc_cnt)
        1:       begin acc_p0 <= acc_p0 + (32'(ma0) * 32'(mb0));        acc_p1 <= acc_p1 + (32'(ma1) * 32'(mb1)); end
        2, 3:    begin acc_p0 <= acc_p0 + ((32'(ma0) * 32'(mb0)) << 8);  acc_p1 <= acc_p1 + ((32'(ma1) * 32'(mb1)) << 8); end
        4:       begin acc_p0 <= acc_p0 + ((32'(ma0) * 32'(mb0)) << 16); acc_p1 <= acc_p1 + ((32'(ma1) * 32'(mb1)) << 16); end
        default: ;
      endcase
      if (acc_cnt + 1 >= 6 && !acc_hang) acc_done <= 1'b1;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic wait_accept(output int who);
    who = -1;
    for (int i = 0; i < 60; i++) begin
      #1;
      if (req0_ready || req1_ready) begin
        who   = req1_ready ? 1 : 0;
        t_acc = cyc;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_resp(output int lat);
    lat = -1;
    for (int i = 0; i < 100; i++) begin
      if (resp_valid) begin
        lat = cyc - t_acc;
        return;
      end
      tick();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, {req0_ready, req1_ready}, 2'b00);
    check({tag, "_resp"}, {resp_valid, resp_id, resp_err}, 3'b000);
    check({tag, "_prod"}, {resp_p0, resp_p1}, 64'd0);
    check({tag, "_acc"}, {acc_start, ma0, mb0, ma1, mb1}, 33'd0);
  endtask

  initial begin
    int who, lat, bad;
    logic [31:0] sv0, sv1;
    rst = 1'b1;
    req0_valid = 0; req1_valid = 0; req0_signed = 0; req1_signed = 0;
    req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
    resp_ready = 0; acc_hang = 0;
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();

    // Single request with phase-by-phase operand bytes and latency
    resp_ready = 1;
    req0_a = 32'hFFFF_1234; req0_b = 32'hFFFF_5678; req0_valid = 1;
    wait_accept(who);
    check("t1_grant", who, 0);
    tick(); req0_valid = 0;
    check("t1_start", {acc_start, ma0, mb0, ma1, mb1}, {1'b1, 32'h0});
    tick(); check("t1_pp1", {ma0, mb0, ma1, mb1}, 32'h3478FFFF);
    tick(); check("t1_pp2", {ma0, mb0, ma1, mb1}, 32'h3456FFFF);
    wait_resp(lat);
    check("t1_lat", lat, 8);
    check("t1_p0", resp_p0, 32'h06260060);
    check("t1_p1", resp_p1, 32'hFFFE0001);
    check("t1_id_err", {resp_id, resp_err}, 2'b00);
    tick();

    // Round robin from reset with both requesters held valid
    rst = 1; tick(); rst = 0; tick();
    req0_a = 32'h0003_0002; req0_b = 32'h0005_0007;
    req1_a = 32'h0100_00FF; req1_b = 32'h0100_0101;
    req0_valid = 1; req1_valid = 1;
    for (int k = 0; k < 4; k++) begin
      wait_accept(who);
      check($sformatf("rr_grant%0d", k), who, k % 2);
      wait_resp(lat);
      check($sformatf("rr_id%0d", k), resp_id, k % 2);
      check($sformatf("rr_prod%0d", k), {resp_p1, resp_p0},
            (k % 2) ? {32'h0001_0000, 32'h0000_FFFF} : {32'h0000_000F, 32'h0000_000E});
      tick();
    end
    req0_valid = 0; req1_valid = 0;
    tick(); tick();

    // Response backpressure: outputs stable, no accept while stalled
    resp_ready = 0;
    req0_a = 32'hFFFF_1234; req0_b = 32'hFFFF_5678; req0_valid = 1;
    wait_accept(who);
    check("bp_grant", who, 0);
    tick(); req0_valid = 0; req1_valid = 1;
    wait_resp(lat);
    check("bp_lat", lat, 8);
    sv0 = resp_p0; sv1 = resp_p1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!resp_valid || resp_p0 !== sv0 || resp_p1 !== sv1 || resp_id !== 1'b0 || req0_ready || req1_ready)
        bad++;
    end
    check("bp_stable", bad, 0);
    resp_ready = 1;
    tick();
    wait_accept(who);
    check("bp_next_grant", who, 1);
    tick(); req1_valid = 0;
    wait_resp(lat);
    check("bp_next_prod", {resp_id, resp_p1, resp_p0}, {1'b1, 32'h0001_0000, 32'h0000_FFFF});
    tick(); tick();

    // Accumulator never finishes: timeout error response then recovery
    acc_hang = 1;
    req0_a = 32'hFFFF_1234; req0_b = 32'hFFFF_5678; req0_valid = 1;
    wait_accept(who);
    tick(); req0_valid = 0;
    wait_resp(lat);
    check("to_lat", lat, 6 + TIMEOUT);
    check("to_err", {resp_err, resp_p0, resp_p1}, {1'b1, 64'd0});
    tick();
    acc_hang = 0;
    req0_valid = 1;
    wait_accept(who);
    check("to_recover_grant", who, 0);
    tick(); req0_valid = 0;
    wait_resp(lat);
    check("to_recover", {resp_err, resp_p0, resp_p1}, {1'b0, 32'h06260060, 32'hFFFE0001});
    tick(); tick();

    // Async reset during PP3, then the grant pointer favours req0 again
    req0_valid = 1;
    wait_accept(who);
    tick(); req0_valid = 0;
    tick(); tick(); tick();
    check("rst_pp3_bytes", {ma0, mb0, ma1, mb1}, 32'h1278FFFF);
    rst = 1;
    #1;
    check_reset_outputs("rst_mid");
    tick(); rst = 0; tick();
    req1_a = 32'h0100_00FF; req1_b = 32'h0100_0101;
    req0_valid = 1; req1_valid = 1;
    wait_accept(who);
    check("rst_after_grant", who, 0);
    tick(); req0_valid = 0; req1_valid = 0;
    wait_resp(lat);
    check("rst_after_lat", lat, 8);
    check("rst_after_prod", {resp_p0, resp_p1}, {32'h06260060, 32'hFFFE0001});
    tick(); tick();

    // Signed request: lane0 -2*3, lane1 0x8000*0x8000
    req0_a = 32'h8000_FFFE; req0_b = 32'h8000_0003; req0_signed = 1; req0_valid = 1;
    wait_accept(who);
    tick(); req0_valid = 0; req0_signed = 0;
    wait_resp(lat);
`ifdef MUL_SCHED_SIGNED_EN
    check("sgn_p0", resp_p0, 32'hFFFF_FFFA);
`else
    check("sgn_p0", resp_p0, 32'h0002_FFFA);
`endif
    check("sgn_p1", resp_p1, 32'h4000_0000);
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/mul16_pp_sched.md
# mul16_pp_sched

Two-requester scheduler and sequencer for the shared dual-lane 16x16 partial-product multiplier. It arbitrates round-robin between two requesters and accepts one request carrying two 16-bit operand pairs. It then drives the byte operands of the two 8x8 multipliers for four partial-product cycles and handshakes with the 4-cycle accumulator FSM. Finally it returns both 32-bit products, with optional signed correction, on a shared response port.

## Interface
- TIMEOUT, 16: maximum cycles in WAIT for acc_done before an error response (must be ≥ 4).
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- req0_valid / req1_valid  in  1  request pending.
- req0_ready / req1_ready  out  1  one-cycle accept pulse.
- req0_a / req1_a  in  32  multiplicands: lane0 = [15:0], lane1 = [31:16].
- req0_b / req1_b  in  32  multipliers, same lane mapping.
- req0_signed / req1_signed  in  1  two's-complement operands (used only with MUL_SCHED_SIGNED_EN).
- resp_valid  out  1  response available.
- resp_ready  in  1  consumer accepts response.
- resp_id  out  1  requester index of the response.
- resp_p0 / resp_p1  out  32  lane0 / lane1 products.
- resp_err  out  1  accumulator timeout; both products are 0.
- acc_start  out  1  start/hold to the accumulator.
- acc_done  in  1  accumulator done.
- acc_p0 / acc_p1  in  32  accumulator product1 / product2.
- ma0, mb0, ma1, mb1  out  8  byte operands to the lane0 and lane1 8x8 multipliers.

## Operation
- States: IDLE, START, PP1, PP2, PP3, PP4, WAIT, RESP, DRAIN. Reset state is IDLE.
- IDLE arbitration is round-robin.
  - The requester not granted last wins when both are valid.
  - After reset, req0 has priority.
  - The grant pointer updates only on accept.
- On accept, the block pulses the winner's reqN_ready and captures a, b, signed and id. Next state is START.
- START: acc_start=1, all operand bytes 0.
- PP1..PP4 present, per lane k:
  - PP1: (A_L, B_L)
  - PP2: (A_L, B_H)
  - PP3: (A_H, B_L)
  - PP4: (A_H, B_H)
  - acc_start=1 throughout.
- Operand bytes are 0 in every state other than PP1..PP4.
- WAIT:
  - acc_start=1 and the timeout counter increments.
  - If acc_done=1, the block captures acc_p0/acc_p1 (after sign correction) and moves to RESP.
  - If the counter reaches TIMEOUT, the block captures 0, sets err and moves to RESP.
- RESP:
  - acc_start=0 and resp_valid=1, with outputs held stable until resp_ready.
  - On resp_valid & resp_ready, next state is DRAIN.
- DRAIN: stays until acc_done=0, then moves to IDLE. This prevents a stale done from being captured by the next operation.
- Requests arriving outside IDLE wait; reqN_ready stays 0.
- A response is never dropped. Backpressure on resp_ready stalls the block in RESP indefinitely.
- Async rst mid-operation returns the block to IDLE and clears the captured state. The accumulator shares the same rst.

## Timing
- Reset values:
  - req0_ready=0, req1_ready=0
  - resp_valid=0, resp_id=0, resp_p0=0, resp_p1=0, resp_err=0
  - acc_start=0
  - all operand bytes 0
  - grant pointer favours req0.
- Let T be the accept cycle:
  - T+1: START
  - T+2..T+5: PP1..PP4
  - T+6: accumulator enters DONE
  - T+7: acc_done=1 is seen and products are captured
  - T+8: resp_valid=1
- With resp_ready held high: resp at T+8, DRAIN at T+9 (acc_done=1), acc_done falls and the next accept happens at T+10 or T+11.
- Throughput is one request per 10–11 cycles.
- All outputs are registered or decoded from the state register. There is no combinational path from request inputs to outputs, except that reqN_ready is decoded in IDLE.

## Configuration
- MUL_SCHED_SIGNED_EN defined:
  - When the captured signed bit is 1, the block sends operand magnitudes (|x|, where −32768 becomes 0x8000) to the multipliers.
  - neg_k = a_k[15] ^ b_k[15].
  - The captured product is negated as a 32-bit two's complement when neg_k=1.
- MUL_SCHED_SIGNED_EN undefined: reqN_signed is ignored and all arithmetic is unsigned. No magnitude or negation logic is present.

## Test plan
- Single request: req0 a=0xFFFF_1234, b=0xFFFF_5678 → resp_p0=0x06260060, resp_p1=0xFFFE0001, id=0, resp_valid at T+8.
- Both requesters valid continuously, 4 ops → grant order 0,1,0,1, ids match and operands are not mixed.
- resp_ready held low for 20 cycles → resp fields stable, no accept on either port, the next op starts only after the handshake.
- Accumulator model never asserts done → resp_err=1, products 0, resp_valid at T+6+TIMEOUT, then the block returns to IDLE after DRAIN.
- rst asserted in PP3 → all outputs return to reset values immediately; the next request completes correctly.
- With MUL_SCHED_SIGNED_EN: signed=1, lane0 −2×3 → 0xFFFFFFFA, lane1 0x8000×0x8000 → 0x40000000. Without the macro, the same inputs give 0x0002FFFA and 0x40000000.
